// File: rtl/font_rom.sv
// 8x16 digit-only glyph ROM for the score/HUD renderer.
// addr = {char[6:0], row[3:0]}; data bit 7 is the leftmost pixel.
module font_rom #(
  parameter bit REGISTERED = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  localparam int unsigned NDIG  = 10;
  localparam int unsigned NROWS = 10;

  // Rows 2..11 of each digit, digit-major.
  localparam logic [7:0] GLYPH [NDIG*NROWS] = '{
    8'h7C, 8'hC6, 8'hC6, 8'hCE, 8'hDE,
    8'hF6, 8'hE6, 8'hC6, 8'hC6, 8'h7C,
    8'h18, 8'h38, 8'h78, 8'h18, 8'h18,
    8'h18, 8'h18, 8'h18, 8'h18, 8'h7E,
    8'h7C, 8'hC6, 8'h06, 8'h0C, 8'h18,
    8'h30, 8'h60, 8'hC0, 8'hC6, 8'hFE,
    8'h7C, 8'hC6, 8'h06, 8'h06, 8'h3C,
    8'h06, 8'h06, 8'h06, 8'hC6, 8'h7C,
    8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'hCC,
    8'hFE, 8'h0C, 8'h0C, 8'h0C, 8'h1E,
    8'hFE, 8'hC0, 8'hC0, 8'hC0, 8'hFC,
    8'h06, 8'h06, 8'h06, 8'hC6, 8'h7C,
    8'h38, 8'h60, 8'hC0, 8'hC0, 8'hFC,
    8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h7C,
    8'hFE, 8'hC6, 8'h06, 8'h06, 8'h0C,
    8'h18, 8'h30, 8'h30, 8'h30, 8'h30,
    8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'h7C,
    8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h7C,
    8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'h7E,
    8'h06, 8'h06, 8'h06, 8'h0C, 8'h78
  };

  logic [6:0] chr;
  logic [3:0] row;
  logic       is_digit;
  logic       in_body;
  logic [6:0] idx;
  logic [7:0] rom_q;

  assign chr = addr[10:4];
  assign row = addr[3:0];

  // Only '0'..'9' in rows 2..11 hold pixels; everything else is blank.
  assign is_digit = (chr[6:4] == 3'b011) && (chr[3:0] <= 4'd9);
  assign in_body  = (row >= 4'd2) && (row <= 4'd11);

  // Flat table index: digit*10 + (row-2).
  always_comb begin
    idx = ({3'b000, chr[3:0]} * 7'd10)
        + {3'b000, row} - 7'd2;
  end

  // Glyph lookup with blank default for the undecoded region.
  always_comb begin
    rom_q = 8'h00;
    if (is_digit && in_body) begin
      rom_q = GLYPH[idx];
    end
  end

  if (REGISTERED) begin : g_reg
    logic [7:0] data_q;

    // Output register; reset wins over the lookup.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        data_q <= 8'h00;
      end else begin
        data_q <= rom_q;
      end
    end

    assign data = data_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = ^{Clk, Reset};
    assign data = rom_q;
  end

endmodule

// File: tb/tb_font_rom.sv
// Checks both read modes of font_rom against a digit-table
// reference model; random and directed stimulus.
module tb_font_rom;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [10:0] addr_c;
  logic [10:0] addr_r;
  logic [7:0]  data_c;
  logic [7:0]  data_r;

  int n_run  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  font_rom #(.REGISTERED(1'b0)) u_comb (
    .Clk   (Clk),
    .Reset (Reset),
    .addr  (addr_c),
    .data  (data_c)
  );

  font_rom #(.REGISTERED(1'b1)) u_reg (
    .Clk   (Clk),
    .Reset (Reset),
    .addr  (addr_r),
    .data  (data_r)
  );

  // Bitmap of rows 2..11, top row in the high byte.
  function automatic logic [79:0] digit_bitmap(input int d);
    case (d)
      0: return 80'h7CC6C6CEDEF6E6C6C67C;
      1: return 80'h1838781818181818187E;
      2: return 80'h7CC6060C183060C0C6FE;
      3: return 80'h7CC606063C060606C67C;
      4: return 80'h0C1C3C6CCCFE0C0C0C1E;
      5: return 80'hFEC0C0C0FC060606C67C;
      6: return 80'h3860C0C0FCC6C6C6C67C;
      7: return 80'hFEC606060C1830303030;
      8: return 80'h7CC6C6C67CC6C6C6C67C;
      9: return 80'h7CC6C6C67E0606060C78;
      default: return 80'h0;
    endcase
  endfunction

  function automatic logic [7:0] ref_rom(input logic [10:0] a);
    int c;
    int r;
    logic [79:0] bm;
    c = int'(a[10:4]);
    r = int'(a[3:0]);
    if (c < 48 || c > 57) return 8'h00;
    if (r < 2 || r > 11) return 8'h00;
    bm = digit_bitmap(c - 48);
    return bm[79 - 8*(r-2) -: 8];
  endfunction

  function automatic logic [10:0] mk(input int c, input int r);
    return {c[6:0], r[3:0]};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset  = 1'b1;
    addr_r = mk(8'h38, 2);
    for (int i = 0; i < 2; i++) begin
      step();
      n_run++;
      if (data_r !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_hold%0d got %h want 00", i, data_r);
      end
    end
    Reset = 1'b0;
    step();
    n_run++;
    if (data_r !== 8'h7C) begin
      n_fail++;
      $display("FAIL reset_release got %h want 7C", data_r);
    end
    addr_r = mk(8'h35, 2);
    step();
    n_run++;
    if (data_r !== 8'hFE) begin
      n_fail++;
      $display("FAIL after_release got %h want FE", data_r);
    end
  endtask

  task automatic test_digit0_comb();
    logic [127:0] exp_seq;
    logic [7:0]   e;
    exp_seq = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
    for (int r = 0; r < 16; r++) begin
      addr_c = mk(8'h30, r);
      #1;
      e = exp_seq[127 - 8*r -: 8];
      n_run++;
      if (data_c !== e) begin
        n_fail++;
        $display("FAIL digit0_row%0d got %h want %h", r, data_c, e);
      end
    end
  endtask

  task automatic test_clk_ignored();
    addr_c = mk(8'h33, 6);
    for (int i = 0; i < 4; i++) begin
      Reset = i[0];
      @(negedge Clk);
      #2;
      n_run++;
      if (data_c !== 8'h3C) begin
        n_fail++;
        $display("FAIL comb_clk_ign%0d got %h want 3C", i, data_c);
      end
    end
    Reset = 1'b0;
  endtask

  task automatic test_digits_sweep();
    logic [7:0] e;
    for (int d = 0; d < 10; d++) begin
      for (int r = 0; r < 16; r++) begin
        addr_c = mk(8'h30 + d, r);
        #1;
        e = ref_rom(addr_c);
        n_run++;
        if (data_c !== e) begin
          n_fail++;
          $display("FAIL digit%0d_row%0d got %h want %h",
                   d, r, data_c, e);
        end
      end
    end
  endtask

  task automatic test_spot();
    logic [10:0] a [3];
    logic [7:0]  e [3];
    a[0] = mk(8'h34, 7);  e[0] = 8'hFE;
    a[1] = mk(8'h31, 11); e[1] = 8'h7E;
    a[2] = mk(8'h39, 11); e[2] = 8'h78;
    for (int i = 0; i < 3; i++) begin
      addr_c = a[i];
      #1;
      n_run++;
      if (data_c !== e[i]) begin
        n_fail++;
        $display("FAIL spot%0d got %h want %h", i, data_c, e[i]);
      end
    end
  endtask

  task automatic test_blank();
    logic [10:0] a [4];
    int c;
    a[0] = mk(8'h3A, 5);
    a[1] = mk(8'h41, 6);
    a[2] = mk(8'h20, 0);
    a[3] = mk(8'h7F, 15);
    for (int i = 0; i < 4; i++) begin
      addr_c = a[i];
      #1;
      n_run++;
      if (data_c !== 8'h00) begin
        n_fail++;
        $display("FAIL blank_spot%0d got %h want 00", i, data_c);
      end
    end
    for (int i = 0; i < 2048; i++) begin
      c = i / 16;
      if (c >= 48 && c <= 57) continue;
      addr_c = i[10:0];
      #1;
      n_run++;
      if (data_c !== 8'h00) begin
        n_fail++;
        $display("FAIL blank_addr%0h got %h want 00", i, data_c);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]  e;
    logic [7:0]  pend;
    logic [10:0] a;
    pend = ref_rom(addr_r);
    for (int i = 0; i < 400; i++) begin
      a = 11'($urandom);
      if (i[0]) a[10:4] = 7'(8'h30 + $urandom_range(0, 15));
      addr_r = a;
      addr_c = a;
      #1;
      e = ref_rom(a);
      n_run++;
      if (data_c !== e) begin
        n_fail++;
        $display("FAIL rand_comb%0d addr %h got %h want %h",
                 i, a, data_c, e);
      end
      step();
      n_run++;
      if (data_r !== e) begin
        n_fail++;
        $display("FAIL rand_reg%0d addr %h got %h want %h",
                 i, a, data_r, e);
      end
      pend = e;
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] a [3];
    logic [7:0]  e [3];
    a[0] = mk(8'h32, 11); e[0] = 8'hFE;
    a[1] = mk(8'h37, 2);  e[1] = 8'hFE;
    a[2] = mk(8'h36, 6);  e[2] = 8'hFC;
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr_r = a[i];
      step();
      n_run++;
      if (data_r !== e[i]) begin
        n_fail++;
        $display("FAIL b2b%0d got %h want %h", i, data_r, e[i]);
      end
    end
    addr_r = a[0];
    step();
    n_run++;
    if (data_r !== 8'hFE) begin
      n_fail++;
      $display("FAIL b2b_rst_first got %h want FE", data_r);
    end
    addr_r = a[1];
    Reset  = 1'b1;
    step();
    n_run++;
    if (data_r !== 8'h00) begin
      n_fail++;
      $display("FAIL b2b_rst_drop got %h want 00", data_r);
    end
    Reset  = 1'b0;
    addr_r = a[2];
    step();
    n_run++;
    if (data_r !== 8'hFC) begin
      n_fail++;
      $display("FAIL b2b_rst_resume got %h want FC", data_r);
    end
  endtask

  initial begin
    Reset  = 1'b0;
    addr_c = '0;
    addr_r = '0;
    @(negedge Clk);
    test_reset();
    test_digit0_comb();
    test_clk_ignored();
    test_digits_sweep();
    test_spot();
    test_blank();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
